// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types and defaults for the unified-memory arbiter.
//   addr_t / op_t      : memory address and data word types
//   arb_state_t        : arbiter sequencing states
//   mem_req_t          : one memory-side request (address, write flag, data)
//   STARVE_LIMIT_DEFAULT : default fetch starvation limit
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] op_t;

    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        RESP_IF,
        RESP_LS
    } arb_state_t;

    typedef struct packed {
        addr_t addr;
        logic  write;
        op_t   wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the fetch port, the load/store port and the memory-side signals.
//   slave  : arbiter view (takes requests, drives responses and memory inputs)
//   master : environment view (requesters and memory model)
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    // Fetch port
    logic  if_req_valid;
    logic  if_req_ready;
    addr_t if_req_addr;
    logic  if_resp_valid;
    logic  if_resp_ready;
    op_t   if_resp_data;

    // Load/store port
    logic  ls_req_valid;
    logic  ls_req_ready;
    addr_t ls_req_addr;
    logic  ls_req_write;
    op_t   ls_req_wdata;
    logic  ls_resp_valid;
    logic  ls_resp_ready;
    op_t   ls_resp_data;

    // Memory side
    addr_t mem_addr;
    logic  mem_write_en;
    op_t   mem_write_data;
    op_t   mem_read_data;

    modport slave (
        input  if_req_valid, if_req_addr, if_resp_ready,
        input  ls_req_valid, ls_req_addr, ls_req_write, ls_req_wdata, ls_resp_ready,
        input  mem_read_data,
        output if_req_ready, if_resp_valid, if_resp_data,
        output ls_req_ready, ls_resp_valid, ls_resp_data,
        output mem_addr, mem_write_en, mem_write_data
    );

    modport master (
        output if_req_valid, if_req_addr, if_resp_ready,
        output ls_req_valid, ls_req_addr, ls_req_write, ls_req_wdata, ls_resp_ready,
        output mem_read_data,
        input  if_req_ready, if_resp_valid, if_resp_data,
        input  ls_req_ready, ls_resp_valid, ls_resp_data,
        input  mem_addr, mem_write_en, mem_write_data
    );

endinterface

// File: rtl/mem_arb_resp_slot.sv
// -----------------------------------------------------------------------------
// mem_arb_resp_slot
// One response register with valid/ready hold. Loaded on the grant edge,
// held until the consumer accepts, data kept after valid drops.
//   clk, rst    : clock, synchronous active-high reset
//   load        : grant edge for this port
//   load_data   : word captured on load
//   resp_ready  : consumer accepts the response
//   resp_valid  : response pending
//   resp_data   : captured word
// -----------------------------------------------------------------------------
module mem_arb_resp_slot
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  op_t  load_data,
    input  logic resp_ready,
    output logic resp_valid,
    output op_t  resp_data
);

    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else if (load) begin
            resp_valid <= 1'b1;
            resp_data  <= load_data;
        end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the single-port unified memory between instruction fetch (read only)
// and load/store (read/write). One transaction in flight; load/store has
// priority. With MEM_ARB_STARVE_GUARD_EN defined, fetch is forced to win after
// StarveLimit consecutive lost arbitrations.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_arbiter_if.slave (fetch port, load/store port, memory side)
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned StarveLimit = STARVE_LIMIT_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);

    arb_state_t state;
    logic       grant_if;
    logic       grant_ls;
    logic       force_if;
    mem_req_t   mem_req;
    op_t        ls_capture;
    logic       if_resp_valid_q;
    logic       ls_resp_valid_q;
    op_t        if_resp_data_q;
    op_t        ls_resp_data_q;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned CntW = $clog2(StarveLimit + 1);
    logic [CntW-1:0] if_wait_cnt;

    assign force_if = (if_wait_cnt == CntW'(StarveLimit));

    // Counts arbitrations fetch lost while it was asking; saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_wait_cnt <= '0;
        end else if (grant_if) begin
            if_wait_cnt <= '0;
        end else if (grant_ls && bus.if_req_valid && !force_if) begin
            if_wait_cnt <= if_wait_cnt + 1'b1;
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = ^StarveLimit;
    assign force_if = 1'b0;
`endif

    // Grants are gated by rst so nothing (including the write strobe) leaks
    // out while reset is held.
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (!rst && state == IDLE) begin
            if (bus.ls_req_valid && !(force_if && bus.if_req_valid)) begin
                grant_ls = 1'b1;
            end else if (bus.if_req_valid) begin
                grant_if = 1'b1;
            end
        end
    end

    always_comb begin
        mem_req = '0;
        if (grant_ls) begin
            mem_req.addr  = bus.ls_req_addr;
            mem_req.write = bus.ls_req_write;
            mem_req.wdata = bus.ls_req_write ? bus.ls_req_wdata : '0;
        end else if (grant_if) begin
            mem_req.addr  = bus.if_req_addr;
        end
    end

    assign bus.mem_addr       = mem_req.addr;
    assign bus.mem_write_en   = mem_req.write;
    assign bus.mem_write_data = mem_req.wdata;
    assign bus.if_req_ready   = grant_if;
    assign bus.ls_req_ready   = grant_ls;

    // A store echoes its own data as the acknowledge payload.
    assign ls_capture = bus.ls_req_write ? bus.ls_req_wdata : bus.mem_read_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ls) begin
                        state <= RESP_LS;
                    end else if (grant_if) begin
                        state <= RESP_IF;
                    end
                end
                RESP_IF: if (bus.if_resp_ready) state <= IDLE;
                RESP_LS: if (bus.ls_resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    mem_arb_resp_slot u_if_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (grant_if),
        .load_data  (bus.mem_read_data),
        .resp_ready (bus.if_resp_ready),
        .resp_valid (if_resp_valid_q),
        .resp_data  (if_resp_data_q)
    );

    mem_arb_resp_slot u_ls_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (grant_ls),
        .load_data  (ls_capture),
        .resp_ready (bus.ls_resp_ready),
        .resp_valid (ls_resp_valid_q),
        .resp_data  (ls_resp_data_q)
    );

    assign bus.if_resp_valid = if_resp_valid_q;
    assign bus.if_resp_data  = if_resp_data_q;
    assign bus.ls_resp_valid = ls_resp_valid_q;
    assign bus.ls_resp_data  = ls_resp_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// transaction-level model. Honours MEM_ARB_STARVE_GUARD_EN.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int LIMIT = 4;

    logic clk;
    logic rst;
    mem_arbiter_if bus ();

    mem_arbiter #(.StarveLimit(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memory: combinational read, write on the clock edge.
    logic [31:0] tb_mem [0:255];
    assign bus.mem_read_data = tb_mem[bus.mem_addr[7:0]];
    always @(posedge clk) begin
        if (bus.mem_write_en) tb_mem[bus.mem_addr[7:0]] <= bus.mem_write_data;
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // busy: 0 = nothing outstanding, 1 = fetch response owed, 2 = LS response owed
    int          m_busy;
    logic [31:0] m_if_data;
    logic [31:0] m_ls_data;
    int          m_wait;
    logic [31:0] model_mem [0:255];

    initial begin
        m_busy = 0; m_if_data = '0; m_ls_data = '0; m_wait = 0;
        forever begin
            int          win;
            logic [31:0] e_addr;
            logic [31:0] e_wd;
            logic        e_we;
            @(negedge clk);
            win = 0;
            if (!rst && m_busy == 0) begin
                if (bus.ls_req_valid && !(GUARD && m_wait == LIMIT && bus.if_req_valid)) win = 2;
                else if (bus.if_req_valid) win = 1;
            end
            e_addr = (win == 2) ? bus.ls_req_addr : (win == 1) ? bus.if_req_addr : 32'h0;
            e_we   = (win == 2) && bus.ls_req_write;
            e_wd   = e_we ? bus.ls_req_wdata : 32'h0;
            if (chk_en) begin
                check("if_req_ready",   bus.if_req_ready,   win == 1);
                check("ls_req_ready",   bus.ls_req_ready,   win == 2);
                check("mem_addr",       bus.mem_addr,       e_addr);
                check("mem_write_en",   bus.mem_write_en,   e_we);
                check("mem_write_data", bus.mem_write_data, e_wd);
                check("if_resp_valid",  bus.if_resp_valid,  m_busy == 1);
                check("ls_resp_valid",  bus.ls_resp_valid,  m_busy == 2);
                check("if_resp_data",   bus.if_resp_data,   m_if_data);
                check("ls_resp_data",   bus.ls_resp_data,   m_ls_data);
            end
            if (rst) begin
                m_busy = 0; m_if_data = '0; m_ls_data = '0; m_wait = 0;
            end else if (win == 2) begin
                m_busy = 2;
                if (bus.ls_req_write) begin
                    m_ls_data = bus.ls_req_wdata;
                    model_mem[bus.ls_req_addr[7:0]] = bus.ls_req_wdata;
                end else begin
                    m_ls_data = model_mem[bus.ls_req_addr[7:0]];
                end
                if (bus.if_req_valid && m_wait < LIMIT) m_wait++;
            end else if (win == 1) begin
                m_busy = 1;
                m_if_data = model_mem[bus.if_req_addr[7:0]];
                m_wait = 0;
            end else if (m_busy == 1 && bus.if_resp_ready) begin
                m_busy = 0;
            end else if (m_busy == 2 && bus.ls_resp_ready) begin
                m_busy = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req_valid = 1'b0; bus.if_req_addr = '0; bus.if_resp_ready = 1'b1;
        bus.ls_req_valid = 1'b0; bus.ls_req_addr = '0; bus.ls_req_write = 1'b0;
        bus.ls_req_wdata = '0;   bus.ls_resp_ready = 1'b1;
    endtask

    // Complete whatever is pending, dropping each valid once it is accepted.
    task automatic drain();
        int   cyc;
        logic ia, la, busy;
        cyc = 0;
        bus.if_resp_ready = 1'b1;
        bus.ls_resp_ready = 1'b1;
        busy = bus.if_req_valid || bus.ls_req_valid || bus.if_resp_valid || bus.ls_resp_valid;
        while (busy && cyc < 40) begin
            @(negedge clk);
            ia = bus.if_req_valid && bus.if_req_ready;
            la = bus.ls_req_valid && bus.ls_req_ready;
            step();
            if (ia) bus.if_req_valid = 1'b0;
            if (la) bus.ls_req_valid = 1'b0;
            busy = bus.if_req_valid || bus.ls_req_valid || bus.if_resp_valid || bus.ls_resp_valid;
            cyc++;
        end
        check("drain_timeout", busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int got, arb, cyc;
        logic ia, la;

        for (int i = 0; i < 256; i++) begin
            tb_mem[i]    = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
            model_mem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
        end
        tb_mem[8'h10]    = 32'hDEAD_BEEF;
        model_mem[8'h10] = 32'hDEAD_BEEF;

        rst = 1'b1;
        idle_inputs();
        repeat (2) step();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_if_resp_valid", bus.if_resp_valid, 1'b0);
        check("rst_ls_resp_data",  bus.ls_resp_data,  32'h0);
        check("rst_mem_write_en",  bus.mem_write_en,  1'b0);
        step();
        rst = 1'b0;

        // Fetch only
        bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h10;
        @(negedge clk);
        check("fetch_req_ready", bus.if_req_ready, 1'b1);
        check("fetch_mem_addr",  bus.mem_addr,     32'h10);
        step();
        bus.if_req_valid = 1'b0;
        @(negedge clk);
        check("fetch_resp_valid", bus.if_resp_valid, 1'b1);
        check("fetch_resp_data",  bus.if_resp_data,  32'hDEAD_BEEF);
        step();

        // Store then load of the same address
        bus.ls_req_valid = 1'b1; bus.ls_req_addr = 32'h40;
        bus.ls_req_write = 1'b1; bus.ls_req_wdata = 32'h1234;
        @(negedge clk);
        check("store_req_ready",  bus.ls_req_ready,   1'b1);
        check("store_write_en",   bus.mem_write_en,   1'b1);
        check("store_write_data", bus.mem_write_data, 32'h1234);
        step();
        bus.ls_req_valid = 1'b0;
        @(negedge clk);
        check("store_resp_data", bus.ls_resp_data, 32'h1234);
        step();
        bus.ls_req_valid = 1'b1; bus.ls_req_write = 1'b0; bus.ls_req_wdata = '0;
        @(negedge clk);
        check("load_write_en", bus.mem_write_en, 1'b0);
        step();
        bus.ls_req_valid = 1'b0;
        @(negedge clk);
        check("load_resp_data", bus.ls_resp_data, 32'h1234);
        step();

        // Contention: LS first, fetch after the LS response is taken
        bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h10;
        bus.ls_req_valid = 1'b1; bus.ls_req_addr = 32'h40;
        @(negedge clk);
        check("contend_ls_ready", bus.ls_req_ready, 1'b1);
        check("contend_if_ready", bus.if_req_ready, 1'b0);
        step();
        bus.ls_req_valid = 1'b0;
        @(negedge clk);
        check("contend_if_wait", bus.if_req_ready, 1'b0);
        step();
        @(negedge clk);
        check("contend_if_granted", bus.if_req_ready, 1'b1);
        step();
        bus.if_req_valid = 1'b0;
        drain();

        // Backpressure on the LS response
        bus.ls_req_valid = 1'b1; bus.ls_req_addr = 32'h44;
        bus.ls_req_write = 1'b1; bus.ls_req_wdata = 32'hCAFE_0001;
        bus.ls_resp_ready = 1'b0;
        bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h10;
        @(negedge clk);
        check("bp_grant", bus.ls_req_ready, 1'b1);
        step();
        bus.ls_req_valid = 1'b0; bus.ls_req_write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_resp_valid", bus.ls_resp_valid, 1'b1);
            check("bp_resp_data",  bus.ls_resp_data,  32'hCAFE_0001);
            check("bp_no_grant",   bus.if_req_ready,  1'b0);
            check("bp_write_en",   bus.mem_write_en,  1'b0);
            step();
        end
        drain();

        // Reset while an LS response is pending
        bus.ls_req_valid = 1'b1; bus.ls_req_addr = 32'h48;
        bus.ls_req_write = 1'b1; bus.ls_req_wdata = 32'h55AA;
        bus.ls_resp_ready = 1'b0;
        @(negedge clk);
        step();
        bus.ls_req_valid = 1'b0; bus.ls_req_write = 1'b0;
        @(negedge clk);
        check("rstmid_pending", bus.ls_resp_valid, 1'b1);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_we_forced", bus.mem_write_en, 1'b0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_ls_valid", bus.ls_resp_valid, 1'b0);
        check("rstmid_ls_data",  bus.ls_resp_data,  32'h0);
        check("rstmid_ls_ready", bus.ls_req_ready,  1'b0);
        step();
        bus.ls_resp_ready = 1'b1;

        // Starvation: LS always asking, fetch asking
        bus.ls_req_valid = 1'b1; bus.ls_req_addr = 32'h20; bus.ls_req_write = 1'b0;
        bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h10;
        got = 0; arb = 0; cyc = 0;
        while (got == 0 && arb < 10 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.if_req_ready) begin
                arb++;
                got = arb;
            end else if (bus.ls_req_ready) begin
                arb++;
            end
            step();
        end
        check("starve_if_grant_arbitration", got, GUARD ? 32'd5 : 32'd0);
        if (got != 0) bus.if_req_valid = 1'b0;
        else          bus.ls_req_valid = 1'b0;
        drain();

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            ia = bus.if_req_valid && bus.if_req_ready;
            la = bus.ls_req_valid && bus.ls_req_ready;
            step();
            if (!bus.if_req_valid || ia) begin
                bus.if_req_valid = ($urandom_range(0, 2) != 0);
                bus.if_req_addr  = 32'($urandom_range(0, 31));
            end
            if (!bus.ls_req_valid || la) begin
                bus.ls_req_valid = ($urandom_range(0, 2) != 0);
                bus.ls_req_addr  = 32'($urandom_range(0, 31));
                bus.ls_req_write = $urandom_range(0, 1) == 1;
                bus.ls_req_wdata = $urandom;
            end
            bus.if_resp_ready = ($urandom_range(0, 3) != 0);
            bus.ls_resp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 63) == 0);
        end
        rst = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
